vec_pack: RTL
=============

# vec_pack

Packs separated, zero-padded vectors back into a continuous stream with no gaps, where vectors straddle bus-word boundaries. Each input vector arrives as exactly two bus words: a full word followed by a zero-padded remainder word. It is the transmit-side counterpart of the vector separator and sits in front of the accelerator input FIFO, or in the host-side loopback path of the bench. Batch boundaries are carried through: the last vector of a batch is flushed and tagged on the output.

## Interface
- BUS_WIDTH, 512, bus word width; constraint BUS_WIDTH < VECTOR_WIDTH <= 2*BUS_WIDTH
- VECTOR_WIDTH, 920, vector width in bits
- Derived: REM = VECTOR_WIDTH-BUS_WIDTH (valid bits in second word); DELTA = 2*BUS_WIDTH-VECTOR_WIDTH (pad bits); FILL_W = $clog2(2*BUS_WIDTH)+1
- clk  in  1  clock; all logic on rising edge
- rstn  in  1  reset; one clock, reset is asynchronous and active-low
- i_Vector  in  BUS_WIDTH  separated vector word
- i_Valid  in  1  i_Vector valid
- i_Last  in  1  sampled only on second word: vector is the last of its batch
- o_Read  out  1  input accepted this cycle (word transfers when i_Valid && o_Read)
- o_Vector  out  BUS_WIDTH  packed stream word
- o_Valid  out  1  o_Vector valid
- i_Ready  in  1  downstream accepts o_Vector this cycle
- o_Last  out  1  final word of a batch
- o_PadErr  out  1  sticky pad-check error (see Configuration)

## Operation
- Bit order is MSB-first throughout. The first word carries vector bits [VW-1 -: BUS_WIDTH]. The second word carries the remaining REM bits in i_Vector[BUS_WIDTH-1 -: REM]; its low DELTA bits are pad and are discarded.
- Storage: 2*BUS_WIDTH-bit accumulator acc, MSB-aligned, plus a fill counter (FILL_W bits, invariant fill < 2*BUS_WIDTH).
- FSM states:
  - S_FIRST: expect first word.
  - S_SECOND: expect second word.
  - S_FLUSH: draining the batch tail.
- FSM transitions:
  - S_FIRST -> S_SECOND on accept.
  - S_SECOND -> S_FIRST on accept with i_Last=0.
  - S_SECOND -> S_FLUSH on accept with i_Last=1.
  - S_FLUSH -> S_FIRST when the o_Last word is loaded.
- emit = (fill >= BUS_WIDTH) && (!o_Valid || i_Ready). On emit:
  - output register <= acc[2B-1 -: B];
  - acc shifts left by B;
  - fill -= B.
- o_Read = (state != S_FLUSH) && (fill < BUS_WIDTH || emit). o_Read depends combinationally on i_Ready.
- On accept:
  - contribution c = BUS_WIDTH in S_FIRST, REM in S_SECOND.
  - Bits are written at acc[2B-1-fill' -: c], where fill' is the post-emit fill from the same cycle.
  - fill = fill' + c.
- Accept and emit may occur in the same cycle.
- Flush in S_FLUSH, when the output slot is free:
  - If fill > BUS_WIDTH: normal emit, o_Last=0.
  - Otherwise: emit acc top word, zero-filled below fill bits, with o_Last=1; fill <= 0.
- Output holds: o_Vector and o_Last stay stable while o_Valid && !i_Ready. o_Valid clears on i_Ready when no new emit occurs.
- i_Last on a first word is ignored.

## Timing
- Reset values (async): o_Valid=0, o_Last=0, o_Vector=0, o_PadErr=0, fill=0, acc=0, state=S_FIRST.
- Reset mid-operation discards all partial data. No o_Last is generated for the interrupted batch.
- Latency: a word accepted at cycle t can first appear on o_Vector at t+2.
- Throughput: one input word per cycle sustained while i_Ready=1. The output needs VW/BW (< 2) words per 2 input words, so it never throttles.
- With i_Ready held low: the output register stays full; o_Read drops once fill >= BUS_WIDTH; no data is lost.
- Exact-fit tail (fill == BUS_WIDTH in S_FLUSH): a full word is emitted with o_Last=1 and no padding.

## Configuration
- VEC_PACK_PAD_CHECK_EN
  - Defined: on each accepted second word with i_Vector[DELTA-1:0] != 0, o_PadErr sets the following cycle and stays set until reset. Data is still packed normally.
  - Undefined: no check logic is built and o_PadErr is tied to 0.

## Test plan
Bench parameters: BUS_WIDTH=8, VECTOR_WIDTH=12 (REM=4, DELTA=4).
- Single vector 0xABC: input 0xAB, 0xC0 (i_Last=1) -> output 0xAB, then 0xC0 with o_Last=1.
- Exact fit, vectors 0xABC, 0x123 (last): input 0xAB, 0xC0, 0x12, 0x30 (i_Last=1) -> output 0xAB, 0xC1, 0x23 with o_Last=1 on 0x23; no fourth word.
- Three vectors 0xABC, 0x123, 0xABC (last), input back-to-back -> output 0xAB, 0xC1, 0x23, 0xAB, 0xC0 with o_Last only on 0xC0; o_Read continuously high.
- Backpressure: i_Ready=0 for 5 cycles mid-stream -> o_Vector stable, o_Read=0 once fill>=8; output sequence is identical to the unstalled run.
- Reset mid-batch: assert rstn=0 after 0xAB is accepted -> o_Valid=0 immediately; a subsequent 0x12, 0x30 (last) yields 0x12, 0x30 with o_Last=1.
- Pad check (VEC_PACK_PAD_CHECK_EN defined): second word 0xC5 -> o_PadErr=1 from the next cycle and sticky; data output is unchanged (0xC0 tail).

Source files
------------

// File: rtl/vec_pack.sv
// vec_pack: repacks two-word, zero-padded vectors into a gapless MSB-first stream; batch tails are flushed and tagged with o_Last.
// Latency 2 cycles from accept to output; o_Read drops while the accumulator holds a full word that the output cannot take. Optional macro: VEC_PACK_PAD_CHECK_EN.
module vec_pack #(
  parameter int BUS_WIDTH    = 512,
  parameter int VECTOR_WIDTH = 920
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [BUS_WIDTH-1:0] i_Vector,
  input  logic                 i_Valid,
  input  logic                 i_Last,
  output logic                 o_Read,
  output logic [BUS_WIDTH-1:0] o_Vector,
  output logic                 o_Valid,
  input  logic                 i_Ready,
  output logic                 o_Last,
  output logic                 o_PadErr
);

  localparam int REM    = VECTOR_WIDTH - BUS_WIDTH;
  localparam int DELTA  = 2*BUS_WIDTH - VECTOR_WIDTH;
  localparam int FILL_W = $clog2(2*BUS_WIDTH) + 1;
  localparam logic [FILL_W-1:0]    BW_F     = FILL_W'(BUS_WIDTH);
  localparam logic [FILL_W-1:0]    REM_F    = FILL_W'(REM);
  localparam logic [BUS_WIDTH-1:0] REM_MASK = {BUS_WIDTH{1'b1}} << DELTA;

  typedef enum logic [1:0] {S_FIRST, S_SECOND, S_FLUSH} state_t;

  state_t                 r_state, w_state_nxt;
  logic [2*BUS_WIDTH-1:0] r_acc;
  logic [FILL_W-1:0]      r_fill;
  logic [BUS_WIDTH-1:0]   r_out_dat;
  logic                   r_out_vld;
  logic                   r_out_last;

  logic                   w_slot_free;
  logic                   w_emit_norm;
  logic                   w_emit_last;
  logic                   w_emit;
  logic                   w_accept;
  logic [FILL_W-1:0]      w_fill_post;
  logic [2*BUS_WIDTH-1:0] w_acc_post;
  logic [2*BUS_WIDTH-1:0] w_ins;
  logic [FILL_W-1:0]      w_contrib;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_FIRST;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FIRST:  if (w_accept) w_state_nxt = S_SECOND;
      S_SECOND: if (w_accept) w_state_nxt = i_Last ? S_FLUSH : S_FIRST;
      S_FLUSH:  if (w_emit_last) w_state_nxt = S_FIRST;
      default:  w_state_nxt = S_FIRST;
    endcase
  end

  // In flush, a tail of exactly one word or less goes out as the tagged last word.
  always_comb begin
    w_slot_free = !r_out_vld || i_Ready;
    w_emit_norm = 1'b0;
    w_emit_last = 1'b0;
    if (r_state == S_FLUSH) begin
      w_emit_norm = w_slot_free && (r_fill > BW_F);
      w_emit_last = w_slot_free && (r_fill <= BW_F);
    end else begin
      w_emit_norm = w_slot_free && (r_fill >= BW_F);
    end
    w_emit   = w_emit_norm || w_emit_last;
    o_Read   = (r_state != S_FLUSH) && ((r_fill < BW_F) || w_emit_norm);
    w_accept = i_Valid && o_Read;
  end

  always_comb begin
    w_fill_post = w_emit_norm ? (r_fill - BW_F) : r_fill;
    w_acc_post  = w_emit_norm ? (r_acc << BUS_WIDTH) : r_acc;
    w_contrib   = (r_state == S_SECOND) ? REM_F : BW_F;
    w_ins       = {((r_state == S_SECOND) ? (i_Vector & REM_MASK) : i_Vector),
                   {BUS_WIDTH{1'b0}}} >> w_fill_post;
  end

  // Bits below fill are always zero, so OR-ing new data in is sufficient.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_acc  <= '0;
      r_fill <= '0;
    end else if (w_emit_last) begin
      r_acc  <= '0;
      r_fill <= '0;
    end else if (w_accept) begin
      r_acc  <= w_acc_post | w_ins;
      r_fill <= w_fill_post + w_contrib;
    end else begin
      r_acc  <= w_acc_post;
      r_fill <= w_fill_post;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_out_dat  <= '0;
      r_out_vld  <= 1'b0;
      r_out_last <= 1'b0;
    end else if (w_emit) begin
      r_out_dat  <= r_acc[2*BUS_WIDTH-1 -: BUS_WIDTH];
      r_out_vld  <= 1'b1;
      r_out_last <= w_emit_last;
    end else if (i_Ready) begin
      r_out_vld  <= 1'b0;
      r_out_last <= 1'b0;
    end
  end

  assign o_Vector = r_out_dat;
  assign o_Valid  = r_out_vld;
  assign o_Last   = r_out_last;

`ifdef VEC_PACK_PAD_CHECK_EN
  logic r_pad_err;
  logic w_pad_bad;
  assign w_pad_bad = |(i_Vector & ~REM_MASK);
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                          r_pad_err <= 1'b0;
    else if (w_accept && (r_state == S_SECOND) && w_pad_bad) r_pad_err <= 1'b1;
  end
  assign o_PadErr = r_pad_err;
`else
  assign o_PadErr = 1'b0;
`endif

endmodule
